// File: rtl/usb_m4_bridge_wb.sv
// usb_m4_bridge_wb: Wishbone classic slave giving the M4 access to the u2m
// (USB OUT -> M4) and m2u (M4 -> USB IN) first-word-fall-through FIFOs, with
// status flags, sticky error bits, byte counters and a maskable interrupt.
// Every access runs IDLE -> EXEC -> ACK -> SETTLE so FIFO flags always
// reflect the previous pop/push before the next access is sampled.
module usb_m4_bridge_wb #(
  parameter int unsigned ADR_W         = 5,
  parameter int unsigned CNT_W         = 16,
  parameter logic [3:0]  RX_THRESH_RST = 4'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  // Wishbone classic slave
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             irq_o,
  // u2m FIFO read side
  output logic             FIFO_u2m_pop,
  input  logic [7:0]       FIFO_u2m_dout,
  input  logic             FIFO_u2m_empty,
  input  logic             FIFO_u2m_ae,
  input  logic [3:0]       FIFO_u2m_popflag,
  // m2u FIFO write side
  output logic             FIFO_m2u_push,
  output logic [7:0]       FIFO_m2u_din,
  input  logic             FIFO_m2u_full,
  input  logic             FIFO_m2u_af,
  input  logic [3:0]       FIFO_m2u_pushflag
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_ACK    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [2:0] REG_DATA      = 3'd0;
  localparam logic [2:0] REG_STATUS    = 3'd1;
  localparam logic [2:0] REG_IRQ_EN    = 3'd2;
  localparam logic [2:0] REG_IRQ_STAT  = 3'd3;
  localparam logic [2:0] REG_RX_THRESH = 3'd4;
  localparam logic [2:0] REG_RX_CNT    = 3'd5;
  localparam logic [2:0] REG_TX_CNT    = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  // Request captured when the strobe is sampled, so a dropped cycle
  // mid-access still completes exactly once with the original request.
  logic [2:0]       req_reg_q;
  logic             req_we_q;
  logic             req_sel0_q;
  logic [7:0]       req_dat_q;

  logic [31:0]      dat_o_q, dat_o_d;
  logic             pop_q, pop_d;
  logic             push_q, push_d;
  logic [7:0]       din_q, din_d;
  logic             irq_q, irq_d;
  logic [3:0]       irq_en_q, irq_en_d;
  logic [3:0]       rx_thresh_q, rx_thresh_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             rx_uf_q, rx_uf_d;
  logic             tx_ov_q, tx_ov_d;

  logic             latch_req;
  logic             exec_en;
  logic             ack_c;
  logic             set_uf, set_ov, clr_uf, clr_ov;
  logic             rx_avail, tx_space;
  logic [3:0]       irq_src;
  logic [31:0]      rd_mux;

  // Upper data bits, upper byte lanes and the byte offset never matter.
  logic             unused_bits;
  assign unused_bits = ^{wb_dat_i[31:8], wb_sel_i[3:1], wb_adr_i};

  // Raw interrupt sources: data waiting above threshold, room to push, errors.
  assign rx_avail = ~FIFO_u2m_empty & (FIFO_u2m_popflag >= rx_thresh_q);
  assign tx_space = ~FIFO_m2u_af;
  assign irq_src  = {tx_ov_q, rx_uf_q, tx_space, rx_avail};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: one access per pass, no early exit once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (wb_cyc_i && wb_stb_i) state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_ACK;
      ST_ACK:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode of the state: request latch, execute enable, acknowledge.
  always_comb begin
    latch_req = 1'b0;
    exec_en   = 1'b0;
    ack_c     = 1'b0;
    case (state_q)
      ST_IDLE: latch_req = wb_cyc_i & wb_stb_i;
      ST_EXEC: exec_en   = 1'b1;
      ST_ACK:  ack_c     = 1'b1;
      default: ;
    endcase
  end

  // Read multiplexer over the latched register select.
  always_comb begin
    rd_mux = 32'h0;
    case (req_reg_q)
      REG_DATA:      rd_mux[7:0] = FIFO_u2m_empty ? 8'h00 : FIFO_u2m_dout;
      REG_STATUS:    rd_mux[13:0] = {tx_ov_q, rx_uf_q, FIFO_m2u_pushflag,
                                     FIFO_u2m_popflag, FIFO_m2u_af,
                                     FIFO_m2u_full, FIFO_u2m_ae,
                                     FIFO_u2m_empty};
      REG_IRQ_EN:    rd_mux[3:0] = irq_en_q;
      REG_IRQ_STAT:  rd_mux[3:0] = irq_src;
      REG_RX_THRESH: rd_mux[3:0] = rx_thresh_q;
      REG_RX_CNT:    rd_mux[CNT_W-1:0] = rx_cnt_q;
      REG_TX_CNT:    rd_mux[CNT_W-1:0] = tx_cnt_q;
      default:       rd_mux = 32'h0;
    endcase
  end

  // Access side effects, evaluated only in EXEC so each happens exactly once.
  always_comb begin
    dat_o_d     = dat_o_q;
    pop_d       = 1'b0;
    push_d      = 1'b0;
    din_d       = din_q;
    irq_en_d    = irq_en_q;
    rx_thresh_d = rx_thresh_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    set_uf      = 1'b0;
    set_ov      = 1'b0;
    clr_uf      = 1'b0;
    clr_ov      = 1'b0;
    if (exec_en) begin
      dat_o_d = rd_mux;
      if (req_we_q) begin
        case (req_reg_q)
          REG_DATA: begin
            if (req_sel0_q) begin
              if (!FIFO_m2u_full) begin
                push_d   = 1'b1;
                din_d    = req_dat_q;
                tx_cnt_d = tx_cnt_q + CNT_ONE;
              end else begin
                set_ov = 1'b1;
              end
            end
          end
          REG_IRQ_EN:    irq_en_d = req_dat_q[3:0];
          REG_IRQ_STAT: begin
            clr_uf = req_dat_q[2];
            clr_ov = req_dat_q[3];
          end
          REG_RX_THRESH: rx_thresh_d = req_dat_q[3:0];
          REG_RX_CNT, REG_TX_CNT: begin
            rx_cnt_d = '0;
            tx_cnt_d = '0;
          end
          default: ;
        endcase
      end else if (req_reg_q == REG_DATA) begin
        if (!FIFO_u2m_empty) begin
          pop_d    = 1'b1;
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else begin
          set_uf = 1'b1;
        end
      end
    end
    // A new error in the same cycle as its clear must not be lost.
    rx_uf_d = set_uf | (rx_uf_q & ~clr_uf);
    tx_ov_d = set_ov | (tx_ov_q & ~clr_ov);
    irq_d   = |(irq_src & irq_en_q);
  end

  // Datapath and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_reg_q   <= 3'd0;
      req_we_q    <= 1'b0;
      req_sel0_q  <= 1'b0;
      req_dat_q   <= 8'h00;
      dat_o_q     <= 32'h0;
      pop_q       <= 1'b0;
      push_q      <= 1'b0;
      din_q       <= 8'h00;
      irq_q       <= 1'b0;
      irq_en_q    <= 4'h0;
      rx_thresh_q <= RX_THRESH_RST;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      rx_uf_q     <= 1'b0;
      tx_ov_q     <= 1'b0;
    end else begin
      if (latch_req) begin
        req_reg_q  <= wb_adr_i[4:2];
        req_we_q   <= wb_we_i;
        req_sel0_q <= wb_sel_i[0];
        req_dat_q  <= wb_dat_i[7:0];
      end
      dat_o_q     <= dat_o_d;
      pop_q       <= pop_d;
      push_q      <= push_d;
      din_q       <= din_d;
      irq_q       <= irq_d;
      irq_en_q    <= irq_en_d;
      rx_thresh_q <= rx_thresh_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_uf_q     <= rx_uf_d;
      tx_ov_q     <= tx_ov_d;
    end
  end

  assign wb_dat_o      = dat_o_q;
  assign wb_ack_o      = ack_c;
  assign irq_o         = irq_q;
  assign FIFO_u2m_pop  = pop_q;
  assign FIFO_m2u_push = push_q;
  assign FIFO_m2u_din  = din_q;

endmodule

// File: tb/tb_usb_m4_bridge_wb.sv
// tb_usb_m4_bridge_wb: directed plus randomized Wishbone traffic against
// queue-based FIFO models and a register-level reference model.
module tb_usb_m4_bridge_wb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  wb_adr;
  logic [31:0] wb_wdat;
  logic [31:0] wb_rdat;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic        wb_ack;
  logic        irq;

  logic        u2m_pop;
  logic [7:0]  u2m_dout_r    = 8'h00;
  logic        u2m_empty_r   = 1'b1;
  logic        u2m_ae_r      = 1'b1;
  logic [3:0]  u2m_popflag_r = 4'h0;
  logic        m2u_push;
  logic [7:0]  m2u_din;
  logic        m2u_full_r     = 1'b0;
  logic        m2u_af_r       = 1'b0;
  logic [3:0]  m2u_pushflag_r = 4'h0;

  always #5 clk = ~clk;

  usb_m4_bridge_wb #(.ADR_W(5), .CNT_W(16), .RX_THRESH_RST(4'd1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wb_adr_i         (wb_adr),
    .wb_dat_i         (wb_wdat),
    .wb_dat_o         (wb_rdat),
    .wb_we_i          (wb_we),
    .wb_sel_i         (wb_sel),
    .wb_stb_i         (wb_stb),
    .wb_cyc_i         (wb_cyc),
    .wb_ack_o         (wb_ack),
    .irq_o            (irq),
    .FIFO_u2m_pop     (u2m_pop),
    .FIFO_u2m_dout    (u2m_dout_r),
    .FIFO_u2m_empty   (u2m_empty_r),
    .FIFO_u2m_ae      (u2m_ae_r),
    .FIFO_u2m_popflag (u2m_popflag_r),
    .FIFO_m2u_push    (m2u_push),
    .FIFO_m2u_din     (m2u_din),
    .FIFO_m2u_full    (m2u_full_r),
    .FIFO_m2u_af      (m2u_af_r),
    .FIFO_m2u_pushflag(m2u_pushflag_r)
  );

  // ---------------- FIFO models ----------------
  logic [7:0] u2m_q[$];
  logic [7:0] m2u_q[$];
  int         m2u_cap    = 8;
  bit         pf_ovr_en  = 1'b0;
  logic [3:0] pf_ovr_val = 4'h0;
  int         pop_cnt    = 0;
  int         push_cnt   = 0;
  int         us, ms, fr;

  // FWFT FIFOs: pop/push act on the clock edge, flags follow the new contents.
  always @(posedge clk) begin
    if (u2m_pop) begin
      pop_cnt++;
      if (u2m_q.size() > 0) void'(u2m_q.pop_front());
    end
    if (m2u_push) begin
      push_cnt++;
      m2u_q.push_back(m2u_din);
    end
    us = u2m_q.size();
    ms = m2u_q.size();
    fr = m2u_cap - ms;
    if (fr < 0)  fr = 0;
    if (fr > 15) fr = 15;
    u2m_empty_r    <= (us == 0);
    u2m_ae_r       <= (us <= 1);
    u2m_dout_r     <= (us > 0) ? u2m_q[0] : 8'h00;
    u2m_popflag_r  <= pf_ovr_en ? pf_ovr_val : 4'((us > 15) ? 15 : us);
    m2u_full_r     <= (ms >= m2u_cap);
    m2u_af_r       <= (ms >= m2u_cap - 1);
    m2u_pushflag_r <= 4'(fr);
  end

  // ---------------- register reference model ----------------
  int         exp_rx = 0;
  int         exp_tx = 0;
  bit         exp_uf = 1'b0;
  bit         exp_ov = 1'b0;
  logic [3:0] exp_en = 4'h0;
  logic [3:0] exp_thr = 4'd1;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic last_irq_ack, last_irq_post;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    return {18'h0, exp_ov, exp_uf, m2u_pushflag_r, u2m_popflag_r,
            m2u_af_r, m2u_full_r, u2m_ae_r, u2m_empty_r};
  endfunction

  function automatic logic [3:0] model_src();
    logic rxa;
    rxa = !u2m_empty_r && (u2m_popflag_r >= exp_thr);
    return {exp_ov, exp_uf, !m2u_af_r, rxa};
  endfunction

  task automatic model_reset();
    exp_rx = 0; exp_tx = 0; exp_uf = 1'b0; exp_ov = 1'b0;
    exp_en = 4'h0; exp_thr = 4'd1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One Wishbone classic access; checks ack latency and single-cycle ack.
  task automatic wb_xfer(input bit we, input int r, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    int lat;
    wb_adr = 5'(r << 2);
    wb_we  = we;
    wb_wdat = wd;
    wb_sel = sel;
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb_ack && lat < 10);
    check_val("ack_latency", lat, 2);
    rd = wb_rdat;
    last_irq_ack = irq;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    @(posedge clk); #1;
    check_val("ack_one_cycle", wb_ack, 1'b0);
    last_irq_post = irq;
    @(posedge clk); #1;
    $display("wb %s reg=%0d wdat=%h rdat=%h sel=%h", we ? "WR" : "RD", r, wd, rd, sel);
  endtask

  // Access with model prediction of read data, pop/push count and side effects.
  task automatic do_access(input bit we, input int r, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] exp_rd, rd;
    logic [7:0]  exp_byte;
    int p0, q0, dpop, dpush;
    dpop = 0; dpush = 0; exp_byte = 8'h00;
    case (r)
      0:       exp_rd = (u2m_q.size() > 0) ? {24'h0, u2m_q[0]} : 32'h0;
      1:       exp_rd = model_status();
      2:       exp_rd = {28'h0, exp_en};
      3:       exp_rd = {28'h0, model_src()};
      4:       exp_rd = {28'h0, exp_thr};
      5:       exp_rd = exp_rx;
      6:       exp_rd = exp_tx;
      default: exp_rd = 32'h0;
    endcase
    if (!we && r == 0) begin
      if (u2m_q.size() > 0) begin dpop = 1; exp_rx = (exp_rx + 1) & 16'hffff; end
      else exp_uf = 1'b1;
    end
    if (we) begin
      case (r)
        0: if (sel[0]) begin
             if (m2u_q.size() >= m2u_cap) exp_ov = 1'b1;
             else begin dpush = 1; exp_byte = wd[7:0]; exp_tx = (exp_tx + 1) & 16'hffff; end
           end
        2: exp_en = wd[3:0];
        3: begin if (wd[2]) exp_uf = 1'b0; if (wd[3]) exp_ov = 1'b0; end
        4: exp_thr = wd[3:0];
        5, 6: begin exp_rx = 0; exp_tx = 0; end
        default: ;
      endcase
    end
    p0 = pop_cnt;
    q0 = push_cnt;
    wb_xfer(we, r, wd, sel, rd);
    if (!we) check_val($sformatf("read_reg%0d", r), rd, exp_rd);
    check_val("pop_count", pop_cnt - p0, dpop);
    check_val("push_count", push_cnt - q0, dpush);
    if (dpush == 1) check_val("push_data", m2u_q[$], exp_byte);
  endtask

  task automatic check_irq(input string tag);
    tick(1);
    check_val(tag, irq, |(model_src() & exp_en));
  endtask

  initial begin
    logic [3:0] sel;
    int op, n, r;
    reset_n = 1'b0;
    wb_adr = 5'h0; wb_wdat = 32'h0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    tick(3);

    // Reset values
    check_val("rst_ack", wb_ack, 1'b0);
    check_val("rst_dat", wb_rdat, 32'h0);
    check_val("rst_irq", irq, 1'b0);
    check_val("rst_pop", u2m_pop, 1'b0);
    check_val("rst_push", m2u_push, 1'b0);
    check_val("rst_din", m2u_din, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    tick(2);
    do_access(1'b0, 4, 32'h0, 4'hf);

    // 1: three bytes read in order, one pop each
    u2m_q.push_back(8'h41); u2m_q.push_back(8'h42); u2m_q.push_back(8'h43);
    tick(2);
    for (int i = 0; i < 3; i++) do_access(1'b0, 0, 32'h0, 4'hf);
    do_access(1'b0, 5, 32'h0, 4'hf);
    check_val("t1_rx_cnt", exp_rx, 3);

    // 2: underflow on empty read, then W1C
    do_access(1'b0, 0, 32'h0, 4'hf);
    do_access(1'b0, 1, 32'h0, 4'hf);
    do_access(1'b1, 3, 32'h4, 4'hf);
    do_access(1'b0, 1, 32'h0, 4'hf);
    check_irq("t2_irq");

    // 3: overflow on full write, irq follows one cycle after the sticky bit
    do_access(1'b1, 2, 32'h8, 4'hf);
    m2u_cap = 0;
    tick(2);
    check_irq("t3_irq_before");
    do_access(1'b1, 0, 32'h55, 4'h1);
    check_val("t3_irq_at_ack", last_irq_ack, 1'b0);
    check_val("t3_irq_after", last_irq_post, 1'b1);
    do_access(1'b0, 1, 32'h0, 4'hf);
    do_access(1'b0, 6, 32'h0, 4'hf);
    do_access(1'b1, 3, 32'h8, 4'hf);
    do_access(1'b1, 2, 32'h0, 4'hf);

    // 4: back-to-back writes into a FIFO that fills after four bytes
    do_access(1'b1, 5, 32'h0, 4'hf);
    m2u_q.delete();
    m2u_cap = 4;
    tick(2);
    for (int i = 0; i < 8; i++) do_access(1'b1, 0, 32'h10 + i, 4'h1);
    check_val("t4_fifo_size", m2u_q.size(), 4);
    for (int i = 0; i < 4; i++) check_val("t4_fifo_byte", m2u_q[i], 32'h10 + i);
    do_access(1'b0, 1, 32'h0, 4'hf);
    do_access(1'b0, 6, 32'h0, 4'hf);
    do_access(1'b1, 3, 32'h8, 4'hf);

    // 5: rx_avail threshold crossing
    u2m_q.push_back(8'hA1); u2m_q.push_back(8'hA2);
    pf_ovr_en = 1'b1; pf_ovr_val = 4'd3;
    tick(2);
    do_access(1'b1, 2, 32'h1, 4'hf);
    do_access(1'b1, 4, 32'h4, 4'hf);
    check_irq("t5_irq_below");
    pf_ovr_val = 4'd4;
    tick(1);
    check_val("t5_irq_same_cycle", irq, 1'b0);
    tick(1);
    check_val("t5_irq_next_cycle", irq, 1'b1);
    pf_ovr_en = 1'b0;
    tick(2);

    // 6: reset during EXEC aborts the read
    do_access(1'b0, 0, 32'h0, 4'hf);
    n = pop_cnt;
    wb_adr = 5'h0; wb_we = 1'b0; wb_sel = 4'hf; wb_cyc = 1'b1; wb_stb = 1'b1;
    tick(1);
    reset_n = 1'b0;
    #1;
    check_val("t6_ack", wb_ack, 1'b0);
    check_val("t6_pop", u2m_pop, 1'b0);
    check_val("t6_dat", wb_rdat, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick(2);
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    tick(2);
    check_val("t6_no_pop", pop_cnt - n, 0);
    do_access(1'b0, 5, 32'h0, 4'hf);
    do_access(1'b0, 4, 32'h0, 4'hf);

    // Randomized traffic against the model
    u2m_q.delete(); m2u_q.delete(); m2u_cap = 8;
    tick(2);
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0, 1: do_access(1'b0, 0, 32'h0, 4'hf);
        2: begin
          sel = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 3) != 0) sel[0] = 1'b1;
          do_access(1'b1, 0, $urandom, sel);
        end
        3: do_access(1'b0, 1, 32'h0, 4'hf);
        4: begin
          r = $urandom_range(1, 7);
          do_access(1'b0, r, 32'h0, 4'hf);
        end
        5: begin
          r = $urandom_range(1, 7);
          do_access(1'b1, r, $urandom, 4'hf);
        end
        6: begin
          n = $urandom_range(0, 4);
          for (int k = 0; k < n; k++) u2m_q.push_back(8'($urandom));
          tick(2);
        end
        default: begin
          n = $urandom_range(0, 3);
          for (int k = 0; k < n; k++) if (m2u_q.size() > 0) void'(m2u_q.pop_front());
          tick(2);
        end
      endcase
      check_irq("rand_irq");
    end
    do_access(1'b0, 5, 32'h0, 4'hf);
    do_access(1'b0, 6, 32'h0, 4'hf);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/usb_m4_bridge_wb.md
Name: usb_m4_bridge_wb

Overview:
M4-side counterpart of the USB endpoint bridge.
- Pops bytes the USB OUT path pushed into the u2m FIFO.
- Pushes bytes for the USB IN path into the m2u FIFO.
- Exposes both FIFOs to the M4 as a Wishbone classic slave register block, with status flags, sticky error bits, byte counters and a maskable level interrupt.
- Both FIFOs are first-word-fall-through: dout is valid whenever empty=0, and pop advances.

Parameters:
ADR_W, 5, Wishbone byte-address width; register select = wb_adr_i[4:2]
CNT_W, 16, width of the RX/TX byte counters (wrap modulo 2^CNT_W)
RX_THRESH_RST, 4'd1, reset value of the RX threshold field compared against FIFO_u2m_popflag

Ports:
clk  in  1  single system clock, all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
wb_adr_i  in  ADR_W  byte address
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte lanes; only lane 0 is used for DATA writes
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  one-cycle acknowledge
irq_o  out  1  level interrupt, registered
FIFO_u2m_pop  out  1  pop strobe
FIFO_u2m_dout  in  8  FWFT head byte
FIFO_u2m_empty  in  1  u2m empty
FIFO_u2m_ae  in  1  u2m almost empty
FIFO_u2m_popflag  in  4  u2m fill level code (larger = fuller)
FIFO_m2u_push  out  1  push strobe
FIFO_m2u_din  out  8  push data, registered
FIFO_m2u_full  in  1  m2u full
FIFO_m2u_af  in  1  m2u almost full
FIFO_m2u_pushflag  in  4  m2u free-space code (larger = emptier)

Behaviour:
- Reset (reset_n=0, async) values:
  - All outputs 0: wb_ack_o, wb_dat_o, irq_o, FIFO_u2m_pop, FIFO_m2u_push, FIFO_m2u_din.
  - All registers 0, except rx_thresh=RX_THRESH_RST.
  - FSM returns to IDLE. A reset mid-access aborts the access and produces no ack.
- Register map (wb_adr_i[4:2]):
  - 0 DATA: read returns {24'h0, head}; write pushes wb_dat_i[7:0] when wb_sel_i[0]=1.
  - 1 STATUS (RO): [0]u2m_empty [1]u2m_ae [2]m2u_full [3]m2u_af [7:4]u2m_popflag [11:8]m2u_pushflag [12]rx_underflow [13]tx_overflow.
  - 2 IRQ_EN (RW [3:0]): [0]rx_avail [1]tx_space [2]rx_underflow [3]tx_overflow.
  - 3 IRQ_STAT: read returns raw sources [3:0]; writing 1 to bit 2 or bit 3 clears that sticky bit.
  - 4 RX_THRESH (RW [3:0]).
  - 5 RX_CNT (RO, CNT_W bits).
  - 6 TX_CNT (RO, CNT_W bits).
  - 7: reads 0, writes ignored.
  - Any write to RX_CNT or TX_CNT clears both counters.
- FSM states: IDLE -> EXEC -> ACK -> SETTLE -> IDLE.
  - IDLE: wait for wb_cyc_i & wb_stb_i.
  - EXEC: latch the read mux into wb_dat_o. Perform the side effect with a single-cycle registered strobe:
    - DATA read with empty=0: FIFO_u2m_pop=1, RX_CNT+1.
    - DATA read with empty=1: return 0, no pop, set rx_underflow.
    - DATA write with full=0: FIFO_m2u_push=1, din=wb_dat_i[7:0], TX_CNT+1.
    - DATA write with full=1: drop the byte, no push, set tx_overflow.
  - ACK: wb_ack_o=1 for exactly one cycle. Latency is 2 cycles from strobe sample to ack.
  - SETTLE: one dead cycle so FIFO flags reflect the previous pop/push before the next access is sampled. Back-to-back DATA accesses therefore never pop an empty FIFO or push a full one.
- If wb_cyc_i drops during EXEC or ACK, the side effect still completes once, and the FSM still passes through ACK and SETTLE.
- A sticky set and a W1C clear of the same bit in the same cycle: set wins.
- Interrupt sources:
  - rx_avail = !u2m_empty & (u2m_popflag >= rx_thresh).
  - tx_space = !m2u_af.
  - rx_underflow, tx_overflow are the sticky bits.
  - irq_o is registered: |(sources & IRQ_EN), one-cycle latency.
- Counters wrap from all-ones to 0 without a flag.

Test Plan:
1. Reset → push 3 bytes 0x41/0x42/0x43 into the u2m model, then read DATA 3x → wb_dat_o 0x41, 0x42, 0x43. Each ack is 2 cycles after stb, exactly one pop per read. RX_CNT=3.
2. With u2m empty, read DATA → returns 0x0, no pop, STATUS[12]=1. Write IRQ_STAT=0x4 → STATUS[12]=0.
3. Hold m2u_full=1 and write DATA 0x55 → no push, STATUS[13]=1, TX_CNT unchanged. With IRQ_EN=0x8, irq_o=1 one cycle after the bit sets.
4. Back-to-back DATA writes 0x10..0x17 into an m2u model that goes full after 4 → exactly 4 pushes of 0x10..0x13, then overflow set, TX_CNT=4.
5. IRQ_EN=0x1, RX_THRESH=4, drive popflag 3 then 4 with empty=0 → irq_o is 0, then 1 one cycle after popflag=4.
6. Assert reset_n=0 during EXEC of a DATA read → no ack, pop and wb_dat_o forced to 0 immediately. After release, the FSM is in IDLE and RX_CNT=0.
